// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART receiver.
// Each data_valid strobe pushes P_DATA into a 2**ADDR_WIDTH-entry
// circular buffer. The head is shown ahead on a valid/ready pop port.
// A full buffer with no pop drops the incoming byte. Each drop sets a
// sticky OVERFLOW flag and advances a saturating DROP_CNT.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  OUT_READY,
  input  logic                  OVF_CLR,
  output logic                  OUT_VALID,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic [7:0]            DROP_CNT
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  localparam logic [PW-1:0] CNT_ONE    = PW'(1);
  localparam logic [PW-1:0] CNT_ALMOST = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fill_state_e;

  fill_state_e           r_state;
  fill_state_e           w_state_nxt;
  logic                  r_empty;
  logic                  r_full;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_count;
  logic                  r_overflow;
  logic [7:0]            r_drop_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [PW-1:0]         w_wr_ptr_nxt;
  logic [PW-1:0]         w_rd_ptr_nxt;

  // A pop needs a valid head. A push into a full buffer is accepted
  // only when the same cycle frees a slot.
  assign w_pop        = OUT_READY & ~r_empty;
  assign w_push       = data_valid & (~r_full | w_pop);
  assign w_drop       = data_valid & ~w_push;
  assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_push);
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);

  // Fill-level state and pointers. Flags and count come from the next state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values;
      // a blocking = here would let later statements see already-updated state.
      r_state  <= ST_EMPTY;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_empty  <= (w_state_nxt == ST_EMPTY);
      r_full   <= (w_state_nxt == ST_FULL);
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_wr_ptr_nxt - w_rd_ptr_nxt;
    end
  end

  // Next fill-level state from the current level and this cycle's push/pop.
  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt; a path that
    // skipped it would infer a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_push) w_state_nxt = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (w_push && !w_pop && r_count == CNT_ALMOST)
          w_state_nxt = ST_FULL;
        else if (w_pop && !w_push && r_count == CNT_ONE)
          w_state_nxt = ST_EMPTY;
      end
      ST_FULL: begin
        if (w_pop && !w_push) w_state_nxt = ST_PARTIAL;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Storage array written on accepted pushes.
  always_ff @(posedge CLK) begin
    // NOTE: the array has no reset; the pointers and the empty flag already
    // hide stale contents, so resetting every entry would buy nothing.
    if (w_push) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= P_DATA;
  end

  // Sticky overflow and saturating drop count. A drop outranks a clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (OVF_CLR)
        r_drop_cnt <= 8'd1;
      else if (r_drop_cnt != 8'hFF)
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (OVF_CLR) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign OUT_VALID = ~r_empty;
  assign OUT_DATA  = r_empty ? '0 : r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
  assign FULL      = r_full;
  assign EMPTY     = r_empty;
  assign COUNT     = r_count;
  assign OVERFLOW  = r_overflow;
  assign DROP_CNT  = r_drop_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (DATA_WIDTH=8, ADDR_WIDTH=3).
// A queue scoreboard holds the bytes the buffer should contain and
// checks every presented head. Vector tables carry the expected
// level and overflow values. Hand-written sequences cover clear
// versus drop, drop-count saturation and asynchronous reset.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       OUT_READY = 1'b0;
  logic       OVF_CLR = 1'b0;
  logic       OUT_VALID;
  logic [7:0] OUT_DATA;
  logic       FULL;
  logic       EMPTY;
  logic [3:0] COUNT;
  logic       OVERFLOW;
  logic [7:0] DROP_CNT;

  uart_rx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .data_valid(data_valid),
    .P_DATA    (P_DATA),
    .OUT_READY (OUT_READY),
    .OVF_CLR   (OVF_CLR),
    .OUT_VALID (OUT_VALID),
    .OUT_DATA  (OUT_DATA),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .COUNT     (COUNT),
    .OVERFLOW  (OVERFLOW),
    .DROP_CNT  (DROP_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       dv;
    logic [7:0] data;
    logic       rdy;
    logic       clr;
    int         exp_cnt;
    logic       exp_ovf;
    int         exp_drop;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb_q[$];
  bit         m_ovf = 1'b0;
  int         m_drop = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic dv, input logic [7:0] d, input logic rdy,
                              input logic clr, input int cnt, input logic ovf, input int drp);
    vec_t v;
    v.dv = dv; v.data = d; v.rdy = rdy; v.clr = clr;
    v.exp_cnt = cnt; v.exp_ovf = ovf; v.exp_drop = drp;
    vecs.push_back(v);
  endfunction

  // One clock cycle: inputs are driven just after the rising edge. The
  // head is checked at the falling edge and the status just after the
  // next rising edge.
  task automatic cycle(input logic dv, input logic [7:0] d, input logic rdy, input logic clr);
    bit pop, push, drop;
    data_valid = dv; P_DATA = d; OUT_READY = rdy; OVF_CLR = clr;
    @(negedge CLK);
    check("out_valid", OUT_VALID, sb_q.size() != 0);
    if (sb_q.size() == 0) check("out_data_idle", OUT_DATA, 0);
    else                  check("head_data", OUT_DATA, sb_q[0]);
    pop  = rdy && sb_q.size() != 0;
    push = dv && (sb_q.size() < DEPTH || pop);
    drop = dv && !push;
    if (pop)  void'(sb_q.pop_front());
    if (push) sb_q.push_back(d);
    if (drop) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : (m_drop == 255 ? 255 : m_drop + 1);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    @(posedge CLK);
    #1;
    check("count", COUNT, sb_q.size());
    check("full", FULL, sb_q.size() == DEPTH);
    check("empty", EMPTY, sb_q.size() == 0);
    check("overflow", OVERFLOW, m_ovf);
    check("drop_cnt", DROP_CNT, m_drop);
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    // Ordered fill and drain, then READY while empty and a push with pop while empty.
    add(1, 8'hA5, 0, 0, 1, 0, 0);
    add(1, 8'h3C, 0, 0, 2, 0, 0);
    add(1, 8'hFF, 0, 0, 3, 0, 0);
    add(0, 8'h00, 1, 0, 2, 0, 0);
    add(0, 8'h00, 1, 0, 1, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0);
    add(1, 8'h42, 1, 0, 1, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0);
    // Fill to full, then two drops.
    for (int i = 0; i < DEPTH; i++) add(1, 8'(i), 0, 0, i + 1, 0, 0);
    add(1, 8'h55, 0, 0, 8, 1, 1);
    add(1, 8'h66, 0, 0, 8, 1, 2);
    // A push with pop while full keeps the level and does not count as a drop.
    add(1, 8'h99, 1, 0, 8, 1, 2);
    for (int i = 0; i < DEPTH; i++) add(0, 8'h00, 1, 0, DEPTH - 1 - i, 1, 2);
    add(0, 8'h00, 0, 1, 0, 0, 0);

    // Reset state, checked while reset is held and again after release.
    repeat (3) @(negedge CLK);
    check("rst_count", COUNT, 0);
    check("rst_empty", EMPTY, 1);
    check("rst_out_valid", OUT_VALID, 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (5) idle();
    check("idle_empty", EMPTY, 1);
    check("idle_full", FULL, 0);
    check("idle_count", COUNT, 0);
    check("idle_out_valid", OUT_VALID, 0);
    check("idle_out_data", OUT_DATA, 8'h00);
    check("idle_overflow", OVERFLOW, 0);

    // Table-driven vectors.
    foreach (vecs[k]) begin
      cycle(vecs[k].dv, vecs[k].data, vecs[k].rdy, vecs[k].clr);
      check("tbl_count", COUNT, vecs[k].exp_cnt);
      check("tbl_full", FULL, vecs[k].exp_cnt == DEPTH);
      check("tbl_overflow", OVERFLOW, vecs[k].exp_ovf);
      check("tbl_drop_cnt", DROP_CNT, vecs[k].exp_drop);
    end

    // Wrap-around: 20 push/pop pairs with one byte in flight at a time.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("wrap_empty", EMPTY, 1);

    // Sustained one push and one pop per cycle holds the level at one.
    cycle(1'b1, 8'hC0, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
    check("stream_count", COUNT, 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // A clear that coincides with a drop leaves OVERFLOW=1 and DROP_CNT=1.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hE0, 1'b0, 1'b0);
    cycle(1'b1, 8'hE1, 1'b0, 1'b0);
    check("pre_clr_drop_cnt", DROP_CNT, 2);
    cycle(1'b1, 8'hE2, 1'b0, 1'b1);
    check("clr_vs_drop_ovf", OVERFLOW, 1);
    check("clr_vs_drop_cnt", DROP_CNT, 1);
    repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_rst_count", COUNT, 4);

    // Reset in mid-stream takes effect without a clock edge.
    RST = 1'b0;
    #2;
    check("async_count", COUNT, 0);
    check("async_empty", EMPTY, 1);
    check("async_full", FULL, 0);
    check("async_out_valid", OUT_VALID, 0);
    check("async_out_data", OUT_DATA, 0);
    check("async_overflow", OVERFLOW, 0);
    check("async_drop_cnt", DROP_CNT, 0);
    sb_q.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    @(posedge CLK);
    #1;
    RST = 1'b1;

    // DROP_CNT saturates at 255.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    check("sat_drop_cnt", DROP_CNT, 255);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("sat_clr_cnt", DROP_CNT, 0);
    repeat (DEPTH) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0));
    repeat (DEPTH) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer directly downstream of the UART receiver. It captures each `P_DATA` word on the receiver's one-cycle `data_valid` strobe into a circular buffer of 2**ADDR_WIDTH entries. Stored bytes are presented to the consuming logic (register file / system controller) through a valid/ready pop interface. It reports fill level and flags bytes lost to overflow, so a consumer stall never silently corrupts the stream.

## Interface
- `DATA_WIDTH`, default 8: byte width; must match the receiver's `P_DATA`.
- `ADDR_WIDTH`, default 3: log2 of depth; DEPTH = 2**ADDR_WIDTH (8 by default); legal range 1..8.
- `CLK`  in  1: single clock for all logic.
- `RST`  in  1: one clock `CLK`; reset `RST` asynchronous, active-low.
- `data_valid`  in  1: receiver strobe; high exactly one cycle per received byte.
- `P_DATA`  in  DATA_WIDTH: received byte; sampled only when `data_valid`=1.
- `OUT_READY`  in  1: consumer accepts head entry this cycle.
- `OVF_CLR`  in  1: clears `OVERFLOW` and `DROP_CNT`.
- `OUT_VALID`  out  1: head entry available (= not EMPTY).
- `OUT_DATA`  out  DATA_WIDTH: head entry (show-ahead); forced to 0 when `OUT_VALID`=0.
- `FULL`  out  1: COUNT == DEPTH.
- `EMPTY`  out  1: COUNT == 0.
- `COUNT`  out  ADDR_WIDTH+1: entries stored, 0..DEPTH.
- `OVERFLOW`  out  1: sticky; a byte was dropped since the last clear.
- `DROP_CNT`  out  8: saturating count of dropped bytes.

## Operation
- Storage: DEPTH x DATA_WIDTH register array, not reset. Write pointer `wr_ptr` and read pointer `rd_ptr` are ADDR_WIDTH+1 bits wide. The low ADDR_WIDTH bits address the array. Both pointers wrap modulo 2**(ADDR_WIDTH+1).
- COUNT = wr_ptr - rd_ptr (modulo, ADDR_WIDTH+1 bits), registered. EMPTY = (COUNT==0). FULL = (COUNT==DEPTH). FULL and EMPTY are registered, not decoded from stale values.
- Pop: `pop = OUT_READY & OUT_VALID`. A pop increments `rd_ptr`. `OUT_READY` while EMPTY is ignored.
- Push: `push = data_valid & (~FULL | pop)`. A push writes `mem[wr_ptr]` and increments `wr_ptr`.
- Fill-level states (derived from COUNT): EMPTY, PARTIAL, FULL.
  - EMPTY -> PARTIAL on push.
  - PARTIAL -> FULL on push without pop at COUNT==DEPTH-1.
  - PARTIAL -> EMPTY on pop without push at COUNT==1.
  - FULL -> PARTIAL on pop without push.
- Simultaneous push and pop:
  - When not EMPTY: both occur and COUNT is unchanged.
  - When EMPTY: only the push occurs, since `OUT_VALID`=0.
  - When FULL: both occur, FULL stays 1, and no overflow is flagged.
- Overflow: `data_valid` while FULL and no pop drops the byte. Contents and pointers are unchanged. `OVERFLOW` is set to 1 and `DROP_CNT` increments, saturating at 255.
- `OVF_CLR`: zeroes `OVERFLOW` and `DROP_CNT` next edge. If a drop coincides with `OVF_CLR`, the drop wins: `OVERFLOW`=1 and `DROP_CNT`=1.
- No dependency on parity or framing errors; the receiver only strobes `data_valid` for good frames.

## Timing
- Reset values (asynchronous on `RST`=0):
  - `wr_ptr`=`rd_ptr`=0, COUNT=0, EMPTY=1, FULL=0, `OUT_VALID`=0, `OUT_DATA`=0.
  - `OVERFLOW`=0, `DROP_CNT`=0.
- Reset mid-operation discards all stored bytes immediately. Outputs take reset values without waiting for a clock edge.
- Write latency: a byte strobed at edge N is visible on `OUT_DATA`, with `OUT_VALID`=1, after edge N. There is one cycle from the `data_valid` cycle to availability.
- Pop latency: the head advances at the edge where `pop`=1. The next entry (or 0 with `OUT_VALID`=0) is presented the following cycle.
- Back-to-back: a sustained 1 push/cycle with 1 pop/cycle is supported indefinitely. Real UART rate is at most 1 byte per 10*Prescale cycles.
- `OUT_DATA` is a combinational read of `mem[rd_ptr]` masked by `OUT_VALID`. All status outputs are registered.
- FULL/EMPTY/COUNT update in the same edge as the push/pop that changes them.

## Test plan
- Reset then idle: `RST` low, release, 5 cycles -> EMPTY=1, FULL=0, COUNT=0, `OUT_VALID`=0, `OUT_DATA`=0x00, `OVERFLOW`=0.
- Ordered fill/drain: push 0xA5, 0x3C, 0xFF with `OUT_READY`=0, then hold `OUT_READY`=1 -> COUNT 1, 2, 3 on successive pushes; `OUT_DATA` reads 0xA5, 0x3C, 0xFF on consecutive cycles; EMPTY=1 after the third pop.
- Full and overflow: push 0x00..0x07 (DEPTH=8), then push 0x55 and 0x66 with no pop -> FULL=1, COUNT=8, `OVERFLOW`=1, `DROP_CNT`=2. Drain yields 0x00..0x07, with 0x55/0x66 absent.
- Push+pop at FULL: with FULL, strobe 0x99 with `OUT_READY`=1 -> head 0x00 leaves, COUNT stays 8, `OVERFLOW` unchanged. After draining, 0x99 is the last byte.
- Wrap-around: 20 push/pop pairs of incrementing data 0x10..0x23, one in flight at a time -> every byte is returned in order, and pointers wrap past 15 without error.
- Clear vs. drop and async reset: `OVF_CLR` coincident with a drop while FULL -> `OVERFLOW`=1, `DROP_CNT`=1. Then `RST` low mid-stream at COUNT=4 -> COUNT=0 and EMPTY=1 with no clock edge.
